// File: rtl/combo_lock_fsm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : combo_lock_fsm_pkg                                              |
// | Brief    : Shared state encodings, pulse arbitration and width helpers     |
// |            for the keypad combination-lock controller.                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package combo_lock_fsm_pkg;

   localparam int c_STATE_W = 4;

   // State codes are exported on the state port for the LED bank, so the
   // values are fixed explicitly rather than left to the tool.
   typedef enum logic [c_STATE_W-1:0] {
      ST_LOCKED   = 4'd0,
      ST_ENT_L    = 4'd1,
      ST_EVAL_L   = 4'd2,
      ST_OPEN     = 4'd3,
      ST_ENT_U    = 4'd4,
      ST_EVAL_U   = 4'd5,
      ST_CHANGE1  = 4'd6,
      ST_CHANGE2  = 4'd7,
      ST_LOCKOUT  = 4'd8,
      ST_BACKDOOR = 4'd9
   } lock_state_e;

   // The single command that survives arbitration in a given cycle.
   typedef enum logic [2:0] {
      P_NONE     = 3'd0,
      P_ENT      = 3'd1,
      P_CHANGE   = 3'd2,
      P_BACKDOOR = 3'd3,
      P_CLR      = 3'd4
   } pulse_e;

   // Highest-priority pulse wins; every lower-priority pulse is dropped even
   // when the winner has no effect in the current state.
   function automatic pulse_e pick_pulse(input logic clr, input logic backdoor,
                                         input logic change, input logic ent);
      pulse_e p;
      if (clr)           p = P_CLR;
      else if (backdoor) p = P_BACKDOOR;
      else if (change)   p = P_CHANGE;
      else if (ent)      p = P_ENT;
      else               p = P_NONE;
      return p;
   endfunction

   // States in which digits are being keyed in (blink active, entry cleared
   // on arrival).
   function automatic logic is_entry_state(input lock_state_e s);
      return (s == ST_ENT_L) || (s == ST_ENT_U) ||
             (s == ST_CHANGE1) || (s == ST_CHANGE2);
   endfunction

   // Counter width for a count range 0..value-1, never narrower than 1 bit.
   function automatic int clog2_min1(input int value);
      return (value > 2) ? $clog2(value) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/combo_lock_fsm_cyc_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cyc_timer                                                       |
// | Brief    : Cycle counter 0..PERIOD-1 with synchronous load-to-zero,        |
// |            count enable and terminal-count flag. Saturates at the          |
// |            terminal value; a wrapping use reloads on done.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cyc_timer #(
   parameter int PERIOD = 8,
   parameter int W      = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic done
);

   localparam logic [W-1:0] c_LAST = W'(PERIOD - 1);

   logic [W-1:0] r_count;
   logic         w_done;

   assign w_done = (r_count == c_LAST);
   assign done   = w_done;

   // Count up while enabled, hold at the terminal value, restart on load.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= '0;
      end else if (en && !w_done) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/combo_lock_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : combo_lock_fsm                                                  |
// | Brief    : Keypad combination-lock controller. Collects N_DIGITS digits    |
// |            one per ent pulse, opens/locks on compare, locks out after      |
// |            MAX_TRIES consecutive failures, supports a two-pass confirmed   |
// |            code change and a master-code backdoor.                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module combo_lock_fsm
   import combo_lock_fsm_pkg::*;
#(
   parameter int                            N_DIGITS    = 4,
   parameter int                            DIGIT_W     = 4,
   parameter int                            MAX_TRIES   = 3,
   parameter int                            LOCKOUT_CYC = 1000,
   parameter int                            BLINK_CYC   = 50,
   parameter logic [N_DIGITS*DIGIT_W-1:0]   RESET_CODE  = '0,
   parameter logic [N_DIGITS*DIGIT_W-1:0]   MASTER_CODE = 'h0311
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               ent,
   input  logic                               clr,
   input  logic                               change,
   input  logic                               backdoor,
   input  logic [DIGIT_W-1:0]                 sw,
   output logic [3:0]                         state,
   output logic                               is_open,
   output logic                               alarm,
   output logic [$clog2(N_DIGITS)-1:0]        dig_idx,
   output logic [N_DIGITS*DIGIT_W-1:0]        entry,
   output logic                               blink,
   output logic [$clog2(MAX_TRIES+1)-1:0]     tries
);

   localparam int c_CODE_W  = N_DIGITS * DIGIT_W;
   localparam int c_IDX_W   = $clog2(N_DIGITS);
   localparam int c_TRY_W   = $clog2(MAX_TRIES + 1);
   localparam int c_LOCK_W  = clog2_min1(LOCKOUT_CYC);
   localparam int c_BLINK_W = clog2_min1(BLINK_CYC);

   localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(N_DIGITS - 1);
   localparam logic [c_TRY_W-1:0] c_MAX_TRIES = c_TRY_W'(MAX_TRIES);

   // Architectural state
   lock_state_e          r_state;
   logic [c_CODE_W-1:0]  r_code;
   logic [c_CODE_W-1:0]  r_shadow;
   logic [c_CODE_W-1:0]  r_entry;
   logic [c_IDX_W-1:0]   r_dig_idx;
   logic [c_TRY_W-1:0]   r_tries;
   logic                 r_blink;

   // Next-state values
   lock_state_e          w_next_state;
   logic [c_CODE_W-1:0]  w_next_code;
   logic [c_CODE_W-1:0]  w_next_shadow;
   logic [c_CODE_W-1:0]  w_next_entry;
   logic [c_IDX_W-1:0]   w_next_idx;
   logic [c_TRY_W-1:0]   w_next_tries;

   // Helpers
   pulse_e               w_pulse;
   logic [c_CODE_W-1:0]  w_entry_ins;
   logic [c_TRY_W-1:0]   w_tries_inc;
   logic                 w_last_digit;
   logic                 w_match;
   logic                 w_state_chg;
   logic                 w_entering;
   logic                 w_lock_done;
   logic                 w_blink_done;

   assign w_pulse      = pick_pulse(clr, backdoor, change, ent);
   assign w_last_digit = (r_dig_idx == c_LAST_IDX);
   assign w_match      = (r_entry == r_code);
   assign w_tries_inc  = r_tries + 1'b1;
   assign w_state_chg  = (w_next_state != r_state);
   assign w_entering   = is_entry_state(r_state);

   // Current entry with sw written into the slot selected by dig_idx;
   // digit 0 occupies the most significant slot.
   always_comb begin
      w_entry_ins = r_entry;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (c_IDX_W'(i) == r_dig_idx) begin
            w_entry_ins[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = sw;
         end
      end
   end

   // Lockout timer: held at zero outside LOCKOUT, so its first LOCKOUT
   // cycle reads 0 and done marks the last of LOCKOUT_CYC cycles.
   cyc_timer #(
      .PERIOD (LOCKOUT_CYC),
      .W      (c_LOCK_W)
   ) u_lockout_timer (
      .clk  (clk),
      .rst  (rst),
      .load (r_state != ST_LOCKOUT),
      .en   (1'b1),
      .done (w_lock_done)
   );

   // Blink timer: free-runs while digits are being entered, restarting on
   // every state change and on each half-period boundary.
   cyc_timer #(
      .PERIOD (BLINK_CYC),
      .W      (c_BLINK_W)
   ) u_blink_timer (
      .clk  (clk),
      .rst  (rst),
      .load (w_state_chg | ~w_entering | w_blink_done),
      .en   (1'b1),
      .done (w_blink_done)
   );

   // Next-state, code, shadow, entry and attempt-counter decisions.
   always_comb begin
      w_next_state  = r_state;
      w_next_code   = r_code;
      w_next_shadow = r_shadow;
      w_next_entry  = r_entry;
      w_next_idx    = r_dig_idx;
      w_next_tries  = r_tries;

      case (r_state)
         ST_LOCKED: begin
            if ((w_pulse == P_CLR) || (w_pulse == P_ENT)) begin
               w_next_state = ST_ENT_L;
            end else if (w_pulse == P_BACKDOOR) begin
               w_next_state = ST_BACKDOOR;
               w_next_code  = MASTER_CODE;
               w_next_tries = '0;
            end
         end

         ST_ENT_L, ST_ENT_U, ST_CHANGE1, ST_CHANGE2: begin
            if (w_pulse == P_CLR) begin
               w_next_entry = '0;
               w_next_idx   = '0;
            end else if (w_pulse == P_ENT) begin
               w_next_entry = w_entry_ins;
               if (w_last_digit) begin
                  w_next_idx = '0;
                  if (r_state == ST_ENT_L) begin
                     w_next_state = ST_EVAL_L;
                  end else if (r_state == ST_ENT_U) begin
                     w_next_state = ST_EVAL_U;
                  end else if (r_state == ST_CHANGE1) begin
                     // First pass complete: remember it for confirmation.
                     w_next_shadow = w_entry_ins;
                     w_next_state  = ST_CHANGE2;
                  end else begin
                     // Second pass: commit only when both passes agree.
                     if (r_shadow == w_entry_ins) begin
                        w_next_code = r_shadow;
                     end
                     w_next_state = ST_OPEN;
                  end
               end else begin
                  w_next_idx = r_dig_idx + 1'b1;
               end
            end
         end

         ST_EVAL_L: begin
            if (w_match) begin
               w_next_state = ST_OPEN;
               w_next_tries = '0;
            end else begin
               w_next_tries = w_tries_inc;
               w_next_state = (w_tries_inc == c_MAX_TRIES) ? ST_LOCKOUT : ST_LOCKED;
            end
         end

         ST_OPEN: begin
            if ((w_pulse == P_CLR) || (w_pulse == P_ENT)) begin
               w_next_state = ST_ENT_U;
            end else if (w_pulse == P_CHANGE) begin
               w_next_state = ST_CHANGE1;
            end
         end

         ST_EVAL_U: begin
            w_next_state = w_match ? ST_LOCKED : ST_OPEN;
         end

         ST_LOCKOUT: begin
            if (w_lock_done) begin
               w_next_state = ST_LOCKED;
               w_next_tries = '0;
            end
         end

         ST_BACKDOOR: begin
            if (w_pulse == P_ENT) begin
               w_next_state = ST_LOCKED;
            end
         end

         default: begin
            w_next_state = ST_LOCKED;
         end
      endcase

      // Every fresh arrival in a digit-collecting state starts from a blank entry.
      if ((w_next_state != r_state) && is_entry_state(w_next_state)) begin
         w_next_entry = '0;
         w_next_idx   = '0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_LOCKED;
         r_code    <= RESET_CODE;
         r_shadow  <= '0;
         r_entry   <= '0;
         r_dig_idx <= '0;
         r_tries   <= '0;
      end else begin
         r_state   <= w_next_state;
         r_code    <= w_next_code;
         r_shadow  <= w_next_shadow;
         r_entry   <= w_next_entry;
         r_dig_idx <= w_next_idx;
         r_tries   <= w_next_tries;
      end
   end

   // Blink output: toggles at each half-period while entering, cleared on
   // any state change or outside the entry states.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_blink <= 1'b0;
      end else if (w_state_chg || !w_entering) begin
         r_blink <= 1'b0;
      end else if (w_blink_done) begin
         r_blink <= ~r_blink;
      end
   end

   assign state   = r_state;
   assign is_open = (r_state == ST_OPEN) || (r_state == ST_CHANGE1) ||
                    (r_state == ST_CHANGE2);
   assign alarm   = (r_state == ST_LOCKOUT);
   assign dig_idx = r_dig_idx;
   assign entry   = r_entry;
   assign blink   = r_blink;
   assign tries   = r_tries;

endmodule
`default_nettype wire

// File: tb/tb_combo_lock_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_combo_lock_fsm                                               |
// | Brief    : Self-checking bench for combo_lock_fsm: directed scenarios with |
// |            literal expectations plus a randomized run, all outputs         |
// |            compared every cycle against a digit-array behavioural model.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_combo_lock_fsm;
   import combo_lock_fsm_pkg::*;

   localparam int N_DIGITS    = 4;
   localparam int DIGIT_W     = 4;
   localparam int MAX_TRIES   = 3;
   localparam int LOCKOUT_CYC = 1000;
   localparam int BLINK_CYC   = 50;
   localparam int CODE_W      = N_DIGITS * DIGIT_W;
   localparam logic [CODE_W-1:0] RESET_CODE  = 16'h0000;
   localparam logic [CODE_W-1:0] MASTER_CODE = 16'h0311;

   typedef int digits_t [N_DIGITS];

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              ent = 1'b0;
   logic              clr = 1'b0;
   logic              change = 1'b0;
   logic              backdoor = 1'b0;
   logic [DIGIT_W-1:0] sw = '0;
   logic [3:0]        state;
   logic              is_open;
   logic              alarm;
   logic [1:0]        dig_idx;
   logic [CODE_W-1:0] entry;
   logic              blink;
   logic [1:0]        tries;

   int n_checks = 0;
   int n_errors = 0;

   combo_lock_fsm #(
      .N_DIGITS    (N_DIGITS),
      .DIGIT_W     (DIGIT_W),
      .MAX_TRIES   (MAX_TRIES),
      .LOCKOUT_CYC (LOCKOUT_CYC),
      .BLINK_CYC   (BLINK_CYC),
      .RESET_CODE  (RESET_CODE),
      .MASTER_CODE (MASTER_CODE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ent      (ent),
      .clr      (clr),
      .change   (change),
      .backdoor (backdoor),
      .sw       (sw),
      .state    (state),
      .is_open  (is_open),
      .alarm    (alarm),
      .dig_idx  (dig_idx),
      .entry    (entry),
      .blink    (blink),
      .tries    (tries)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit          m_valid = 1'b0;
   lock_state_e m_st;
   digits_t     m_code, m_shadow, m_ent;
   int          m_idx, m_tries, m_age, m_lock_cnt;

   function automatic digits_t unpack_code(input logic [CODE_W-1:0] v);
      digits_t d;
      for (int i = 0; i < N_DIGITS; i++) d[i] = int'(v[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W]);
      return d;
   endfunction

   function automatic logic [CODE_W-1:0] pack_code(input digits_t d);
      logic [CODE_W-1:0] v;
      int t;
      v = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         t = d[i];
         v[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = t[DIGIT_W-1:0];
      end
      return v;
   endfunction

   function automatic bit same(input digits_t a, input digits_t b);
      bit r;
      r = 1'b1;
      for (int i = 0; i < N_DIGITS; i++) if (a[i] != b[i]) r = 1'b0;
      return r;
   endfunction

   function automatic bit collecting(input lock_state_e s);
      return s inside {ST_ENT_L, ST_ENT_U, ST_CHANGE1, ST_CHANGE2};
   endfunction

   task automatic model_reset();
      m_st = ST_LOCKED;
      m_code = unpack_code(RESET_CODE);
      for (int i = 0; i < N_DIGITS; i++) begin m_ent[i] = 0; m_shadow[i] = 0; end
      m_idx = 0; m_tries = 0; m_age = 0; m_lock_cnt = 0;
      m_valid = 1'b1;
   endtask

   task automatic model_step(input logic c, input logic b, input logic ch,
                             input logic e, input logic [DIGIT_W-1:0] s);
      int w;
      lock_state_e nst;
      w = c ? 4 : b ? 3 : ch ? 2 : e ? 1 : 0;
      nst = m_st;
      case (m_st)
         ST_LOCKED:
            if (w == 4 || w == 1) nst = ST_ENT_L;
            else if (w == 3) begin nst = ST_BACKDOOR; m_code = unpack_code(MASTER_CODE); m_tries = 0; end
         ST_ENT_L, ST_ENT_U, ST_CHANGE1, ST_CHANGE2:
            if (w == 4) begin
               for (int i = 0; i < N_DIGITS; i++) m_ent[i] = 0;
               m_idx = 0;
            end else if (w == 1) begin
               m_ent[m_idx] = int'(s);
               if (m_idx == N_DIGITS - 1) begin
                  m_idx = 0;
                  if (m_st == ST_ENT_L) nst = ST_EVAL_L;
                  else if (m_st == ST_ENT_U) nst = ST_EVAL_U;
                  else if (m_st == ST_CHANGE1) begin m_shadow = m_ent; nst = ST_CHANGE2; end
                  else begin
                     if (same(m_shadow, m_ent)) m_code = m_shadow;
                     nst = ST_OPEN;
                  end
               end else m_idx++;
            end
         ST_EVAL_L:
            if (same(m_ent, m_code)) begin nst = ST_OPEN; m_tries = 0; end
            else begin
               m_tries++;
               m_lock_cnt = 0;
               nst = (m_tries == MAX_TRIES) ? ST_LOCKOUT : ST_LOCKED;
            end
         ST_OPEN:
            if (w == 4 || w == 1) nst = ST_ENT_U;
            else if (w == 2) nst = ST_CHANGE1;
         ST_EVAL_U: nst = same(m_ent, m_code) ? ST_LOCKED : ST_OPEN;
         ST_LOCKOUT: begin
            m_lock_cnt++;
            if (m_lock_cnt == LOCKOUT_CYC) begin nst = ST_LOCKED; m_tries = 0; end
         end
         ST_BACKDOOR: if (w == 1) nst = ST_LOCKED;
         default: nst = ST_LOCKED;
      endcase
      if (nst != m_st) begin
         m_age = 0;
         if (collecting(nst)) begin
            for (int i = 0; i < N_DIGITS; i++) m_ent[i] = 0;
            m_idx = 0;
         end
      end else m_age++;
      m_st = nst;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Compare all outputs against the model every cycle once reset has been seen.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("state",   32'(state),   32'(m_st));
         chk("is_open", 32'(is_open), 32'(m_st inside {ST_OPEN, ST_CHANGE1, ST_CHANGE2}));
         chk("alarm",   32'(alarm),   32'(m_st == ST_LOCKOUT));
         chk("dig_idx", 32'(dig_idx), 32'(m_idx));
         chk("entry",   32'(entry),   32'(pack_code(m_ent)));
         chk("tries",   32'(tries),   32'(m_tries));
         chk("blink",   32'(blink),
             32'(collecting(m_st) && (((m_age / BLINK_CYC) % 2) == 1)));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycle(input logic r, input logic c, input logic b, input logic ch,
                        input logic e, input logic [DIGIT_W-1:0] s);
      rst = r; clr = c; backdoor = b; change = ch; ent = e; sw = s;
      @(posedge clk);
      if (r) model_reset();
      else model_step(c, b, ch, e, s);
      @(negedge clk);
      rst = 1'b0; clr = 1'b0; backdoor = 1'b0; change = 1'b0; ent = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
   endtask

   task automatic press(input logic [DIGIT_W-1:0] s);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, s);
   endtask

   task automatic enter_code(input logic [CODE_W-1:0] c);
      for (int i = 0; i < N_DIGITS; i++) press(c[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W]);
   endtask

   // Wake the keypad, key a full code and let the evaluation cycle complete.
   task automatic attempt(input logic [CODE_W-1:0] c);
      press(4'h0);
      enter_code(c);
      idle(1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DIGIT_W-1:0] s;
      int r;
      @(negedge clk);

      // Reset state
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      chk("rst_state", 32'(state), 32'(ST_LOCKED));
      chk("rst_entry", 32'(entry), 32'h0);
      chk("rst_tries", 32'(tries), 32'h0);

      // Default code opens; decision two cycles after the last ent
      press(4'h0);
      chk("wake_state", 32'(state), 32'(ST_ENT_L));
      enter_code(16'h0000);
      chk("eval_state", 32'(state), 32'(ST_EVAL_L));
      idle(1);
      chk("open_state", 32'(state), 32'(ST_OPEN));
      chk("open_flag",  32'(is_open), 32'h1);
      attempt(16'h0000);
      chk("relock", 32'(state), 32'(ST_LOCKED));

      // Three wrong codes lead to lockout
      for (int t = 1; t <= MAX_TRIES; t++) begin
         attempt(16'h1234);
         chk("tries_count", 32'(tries), 32'(t));
         if (t < MAX_TRIES) chk("miss_state", 32'(state), 32'(ST_LOCKED));
      end
      chk("lockout_state", 32'(state), 32'(ST_LOCKOUT));
      chk("lockout_alarm", 32'(alarm), 32'h1);
      for (int i = 0; i < LOCKOUT_CYC - 1; i++)
         cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 4'h0);
      chk("lockout_hold", 32'(state), 32'(ST_LOCKOUT));
      idle(1);
      chk("lockout_exit", 32'(state), 32'(ST_LOCKED));
      chk("lockout_tries", 32'(tries), 32'h0);

      // Confirmed code change to 5678
      attempt(16'h0000);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
      chk("change1", 32'(state), 32'(ST_CHANGE1));
      enter_code(16'h5678);
      chk("change2", 32'(state), 32'(ST_CHANGE2));
      enter_code(16'h5678);
      chk("change_done", 32'(state), 32'(ST_OPEN));
      attempt(16'h5678);
      chk("relock_new", 32'(state), 32'(ST_LOCKED));
      attempt(16'h0000);
      chk("old_fails", 32'(tries), 32'h1);

      // Mismatched confirmation leaves the code alone
      attempt(16'h5678);
      chk("open_new", 32'(state), 32'(ST_OPEN));
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
      enter_code(16'h5678);
      enter_code(16'h5679);
      attempt(16'h5678);
      chk("code_kept", 32'(state), 32'(ST_LOCKED));

      // clr mid-entry, and clr beating a simultaneous ent
      press(4'h0);
      press(4'h1);
      press(4'h2);
      chk("mid_idx",   32'(dig_idx), 32'h2);
      chk("mid_entry", 32'(entry), 32'h1200);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      chk("clr_idx",   32'(dig_idx), 32'h0);
      chk("clr_state", 32'(state), 32'(ST_ENT_L));
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h9);
      chk("clr_wins", 32'(entry), 32'h0);
      enter_code(16'h5678);
      idle(1);
      chk("open_after_clr", 32'(state), 32'(ST_OPEN));
      attempt(16'h5678);

      // Backdoor installs the master code
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      chk("backdoor", 32'(state), 32'(ST_BACKDOOR));
      press(4'h0);
      chk("bd_exit", 32'(state), 32'(ST_LOCKED));
      attempt(16'h0311);
      chk("master_open", 32'(state), 32'(ST_OPEN));

      // Reset mid-CHANGE2 restores the reset code
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
      enter_code(16'h1111);
      press(4'h1);
      press(4'h1);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      chk("rst_abort", 32'(state), 32'(ST_LOCKED));
      attempt(16'h0000);
      chk("reset_code", 32'(state), 32'(ST_OPEN));

      // Randomized traffic, sw biased towards the digits that would match
      for (int k = 0; k < 9000; k++) begin
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 9) < 7)
            s = 4'((m_st == ST_CHANGE2) ? m_shadow[m_idx] : m_code[m_idx]);
         else
            s = 4'($urandom_range(0, 15));
         cycle(($urandom_range(0, 2999) == 0),
               (r < 2) || (r == 99),
               (r >= 2 && r < 4),
               (r >= 4 && r < 7),
               (r >= 7 && r < 15) || (r == 99),
               s);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
